matmul_controller: RTL

MATMUL_CONTROLLER -- requirements
Module: matmul_controller

---
 rtl/matmul_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/matmul_controller.sv
// matmul_controller: computes C = A x B for two N x N unsigned matrices using
// one shared external multiplier. Operands are captured on start, then one
// multiply-accumulate is issued per cycle (k fastest, then j, then i), and
// the finished result is published on out_mat together with a done pulse.
// Optional build macro MATMUL_SAT_EN: accumulations saturate at
// 2^ACC_WIDTH-1 instead of wrapping.
module matmul_controller #(
   parameter int DATA_WIDTH = 4,
   parameter int N          = 2,
   parameter int ACC_WIDTH  = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [N*N*DATA_WIDTH-1:0]     in_mat1,
   input  logic [N*N*DATA_WIDTH-1:0]     in_mat2,
   output logic [DATA_WIDTH-1:0]         mul_a,
   output logic [DATA_WIDTH-1:0]         mul_b,
   input  logic [DATA_WIDTH+3:0]         mul_p,
   output logic                          busy,
   output logic                          done,
   output logic [N*N*ACC_WIDTH-1:0]      out_mat
);

   // Index counters only need to reach N-1 (N is 2..4).
   localparam int IW = (N > 2) ? 2 : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                       state;
   logic [IW-1:0]                i, j, k;
   logic [ACC_WIDTH-1:0]         acc;
   logic [ACC_WIDTH-1:0]         acc_sum;
   logic [N*N*DATA_WIDTH-1:0]    a_reg, b_reg;
   logic [N*N*ACC_WIDTH-1:0]     c_buf, c_next;

   // One accumulation step: partial sum plus zero-extended product,
   // either wrapping or clamping at the top of the result range.
   function automatic logic [ACC_WIDTH-1:0] accumulate(
      input logic [ACC_WIDTH-1:0]  base,
      input logic [DATA_WIDTH+3:0] prod
   );
`ifdef MATMUL_SAT_EN
      logic [ACC_WIDTH:0] wide;
      wide = {1'b0, base} + (ACC_WIDTH+1)'(prod);
      return wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
`else
      return base + ACC_WIDTH'(prod);
`endif
   endfunction

   // Present A[i][k] and B[k][j] to the shared multiplier, zero when not computing.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (state == MAC) begin
         mul_a = a_reg[(int'(i) * N + int'(k)) * DATA_WIDTH +: DATA_WIDTH];
         mul_b = b_reg[(int'(k) * N + int'(j)) * DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Next partial sum and result buffer; the final term of each dot product
   // lands in C[i][j] in the same edge that completes it.
   always_comb begin
      acc_sum = accumulate((k == '0) ? '0 : acc, mul_p);
      c_next  = c_buf;
      if (state == MAC && k == LAST) begin
         c_next[(int'(i) * N + int'(j)) * ACC_WIDTH +: ACC_WIDTH] = acc_sum;
      end
   end

   // Control FSM with index counters, operand capture, accumulator and result publish.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         i       <= '0;
         j       <= '0;
         k       <= '0;
         acc     <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         c_buf   <= '0;
         out_mat <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg <= in_mat1;
                  b_reg <= in_mat2;
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               acc   <= acc_sum;
               c_buf <= c_next;
               if (k == LAST) begin
                  k <= '0;
                  if (j == LAST) begin
                     j <= '0;
                     if (i == LAST) begin
                        i       <= '0;
                        out_mat <= c_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                     end else begin
                        i <= i + 1'b1;
                     end
                  end else begin
                     j <= j + 1'b1;
                  end
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
